// File: rtl/fib_seq_pkg.sv
// Shared types and seed constants for the Fibonacci/Lucas term generator.
package fib_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_t;

  localparam int unsigned FIB_SEED0 = 0;
  localparam int unsigned FIB_SEED1 = 1;
  localparam int unsigned LUC_SEED0 = 2;
  localparam int unsigned LUC_SEED1 = 1;

endpackage

// File: rtl/fib_seq_step.sv
// One recurrence step: next term = prev + curr, with a sticky overflow flag.
module fib_seq_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] curr,
  input  logic             prev_ovf,
  input  logic             curr_ovf,
  output logic [WIDTH-1:0] next_curr,
  output logic             next_curr_ovf
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum           = {1'b0, prev} + {1'b0, curr};
    next_curr     = sum[WIDTH-1:0];
    // any overflowed operand makes the true sum overflow as well
    next_curr_ovf = sum[WIDTH] | prev_ovf | curr_ovf;
  end

endmodule

// File: rtl/fib_seq_gen.sv
// n-th Fibonacci/Lucas term engine with start/ready handshake and overflow flag.
// Optional per-term stream output (term_valid/term) enabled by FIB_SEQ_STREAM_EN.
module fib_seq_gen
  import fib_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NW    = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [NW-1:0]    n,
  input  logic             lucas,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] value,
  output logic             overflow
`ifdef FIB_SEQ_STREAM_EN
  ,
  output logic             term_valid,
  output logic [WIDTH-1:0] term
`endif
);

  fib_state_t       state, state_d;
  logic [WIDTH-1:0] prev, prev_d, curr, curr_d;
  logic             prev_ovf, prev_ovf_d, curr_ovf, curr_ovf_d;
  logic [NW-1:0]    cnt, cnt_d, n_q, n_d;
  logic [WIDTH-1:0] value_d;
  logic             overflow_d, ready_d, busy_d;

  logic [WIDTH-1:0] step_curr;
  logic             step_ovf;

  fib_seq_step #(.WIDTH(WIDTH)) u_step (
    .prev          (prev),
    .curr          (curr),
    .prev_ovf      (prev_ovf),
    .curr_ovf      (curr_ovf),
    .next_curr     (step_curr),
    .next_curr_ovf (step_ovf)
  );

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      prev     <= '0;
      curr     <= '0;
      prev_ovf <= 1'b0;
      curr_ovf <= 1'b0;
      cnt      <= '0;
      n_q      <= '0;
      value    <= '0;
      overflow <= 1'b0;
      ready    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      prev     <= prev_d;
      curr     <= curr_d;
      prev_ovf <= prev_ovf_d;
      curr_ovf <= curr_ovf_d;
      cnt      <= cnt_d;
      n_q      <= n_d;
      value    <= value_d;
      overflow <= overflow_d;
      ready    <= ready_d;
      busy     <= busy_d;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_d    = state;
    prev_d     = prev;
    curr_d     = curr;
    prev_ovf_d = prev_ovf;
    curr_ovf_d = curr_ovf;
    cnt_d      = cnt;
    n_d        = n_q;
    value_d    = value;
    overflow_d = overflow;
    ready_d    = ready;
    busy_d     = busy;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          n_d        = n;
          cnt_d      = '0;
          prev_d     = lucas ? WIDTH'(LUC_SEED0) : WIDTH'(FIB_SEED0);
          curr_d     = lucas ? WIDTH'(LUC_SEED1) : WIDTH'(FIB_SEED1);
          prev_ovf_d = 1'b0;
          curr_ovf_d = 1'b0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (cnt != n_q) begin
          prev_d     = curr;
          curr_d     = step_curr;
          prev_ovf_d = curr_ovf;
          curr_ovf_d = step_ovf;
          cnt_d      = cnt + NW'(1);
        end else begin
          // result is prev; curr is a look-ahead term and is discarded
          value_d    = prev;
          overflow_d = prev_ovf;
          ready_d    = 1'b1;
          busy_d     = 1'b0;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FIB_SEQ_STREAM_EN
  // busy is high exactly in RUN, where prev walks terms 0..n
  assign term_valid = busy;
  assign term       = prev;
`else
  // stream ports absent; core behaviour unchanged
`endif

endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen: vector table plus scoreboard and corner sequences.
module tb_fib_seq_gen;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NW    = 6;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [NW-1:0]    n     = '0;
  logic             lucas = 1'b0;
  logic             busy, ready, overflow;
  logic [WIDTH-1:0] value;
`ifdef FIB_SEQ_STREAM_EN
  logic             term_valid;
  logic [WIDTH-1:0] term;
`endif

  fib_seq_gen #(.WIDTH(WIDTH), .NW(NW)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .n        (n),
    .lucas    (lucas),
    .busy     (busy),
    .ready    (ready),
    .value    (value),
    .overflow (overflow)
`ifdef FIB_SEQ_STREAM_EN
    ,
    .term_valid (term_valid),
    .term       (term)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic             luc;
    logic [NW-1:0]    idx;
    logic [WIDTH-1:0] exp_value;
    logic             exp_ovf;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] value;
    logic             ovf;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   applied    = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit recurrence, term k of the chosen sequence
  function automatic longint unsigned model_term(input logic luc, input int k);
    longint unsigned a, b, t;
    a = luc ? 64'd2 : 64'd0;
    b = 64'd1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic vec_t model_vec(input logic luc, input int k);
    vec_t v;
    longint unsigned t;
    t = model_term(luc, k);
    v.luc       = luc;
    v.idx       = NW'(k);
    v.exp_value = t[WIDTH-1:0];
    v.exp_ovf   = (t >= 64'd65536);
    return v;
  endfunction

  // Issue one job, optionally pulse an intruding start at cycle intr, check latency/result
  task automatic do_job(input logic luc, input int k, input int intr);
    int  cyc, bcyc;
    sb_t e;
    longint unsigned terms[$];
    vec_t mv;
    mv = model_vec(luc, k);
    @(negedge clock);
    start = 1'b1; lucas = luc; n = NW'(k);
    e.value = mv.exp_value; e.ovf = mv.exp_ovf;
    sb_q.push_back(e);
    @(posedge clock); #1;
    start = 1'b0;
    chk("accept_ready_low", ready, 0);
    cyc = 0; bcyc = 0;
    while (!ready && cyc < 200) begin
      if (busy) bcyc++;
`ifdef FIB_SEQ_STREAM_EN
      if (term_valid) terms.push_back(term);
`endif
      if (cyc == intr) begin start = 1'b1; n = NW'(3); lucas = ~luc; end
      else start = 1'b0;
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    if (!ready) begin
      applied++; miscompares++;
      $display("FAIL timeout: n=%0d no ready after %0d cycles", k, cyc);
      sb_q.delete();
      return;
    end
    chk($sformatf("latency n=%0d", k), cyc, k + 1);
    chk($sformatf("busy_cycles n=%0d", k), bcyc, k + 1);
    chk("busy_low_at_ready", busy, 0);
    e = sb_q.pop_front();
    chk($sformatf("value luc=%0d n=%0d", luc, k), value, e.value);
    chk($sformatf("overflow luc=%0d n=%0d", luc, k), overflow, e.ovf);
`ifdef FIB_SEQ_STREAM_EN
    chk($sformatf("stream_beats n=%0d", k), terms.size(), k + 1);
    for (int i = 0; i < terms.size() && i <= k; i++)
      chk($sformatf("stream_term n=%0d k=%0d", k, i), terms[i], model_term(luc, i) & 64'hFFFF);
`endif
  endtask

  initial begin
    // spec-derived constants, then model-derived extras
    vecs.push_back('{1'b0, 6'd10, 16'd55,    1'b0});
    vecs.push_back('{1'b1, 6'd10, 16'd123,   1'b0});
    vecs.push_back('{1'b1, 6'd0,  16'd2,     1'b0});
    vecs.push_back('{1'b0, 6'd0,  16'd0,     1'b0});
    vecs.push_back('{1'b0, 6'd24, 16'd46368, 1'b0});
    vecs.push_back('{1'b0, 6'd25, 16'd9489,  1'b1});
    vecs.push_back('{1'b0, 6'd5,  16'd5,     1'b0});
    vecs.push_back('{1'b0, 6'd1,  16'd1,     1'b0});
    vecs.push_back(model_vec(1'b1, 23));
    vecs.push_back(model_vec(1'b1, 22));
    vecs.push_back(model_vec(1'b0, 63));
    vecs.push_back(model_vec(1'b1, 63));

    #12;
    chk("reset_busy", busy, 0);
    chk("reset_ready", ready, 0);
    chk("reset_value", value, 0);
    chk("reset_overflow", overflow, 0);
    @(negedge clock); reset = 1'b1;

    foreach (vecs[i]) begin
      do_job(vecs[i].luc, int'(vecs[i].idx), -1);
      // table entries must agree with the scoreboard's model-derived expectation
      chk($sformatf("table_value[%0d]", i), value, vecs[i].exp_value);
      chk($sformatf("table_ovf[%0d]", i), overflow, vecs[i].exp_ovf);
    end

    // start pulse during a running n=20 job is ignored
    do_job(1'b0, 20, 5);
    chk("intrude_value", value, 6765);

    // DONE holds its outputs
    repeat (5) @(posedge clock);
    #1;
    chk("done_hold_ready", ready, 1);
    chk("done_hold_value", value, 6765);

    // reset mid-run aborts immediately, no ready afterwards
    @(negedge clock);
    start = 1'b1; lucas = 1'b0; n = NW'(15);
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", ready, 0);
    chk("abort_value", value, 0);
    chk("abort_overflow", overflow, 0);
    @(negedge clock); reset = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    chk("post_abort_ready", ready, 0);
    chk("post_abort_busy", busy, 0);

    // accept from IDLE after reset
    do_job(1'b0, 7, -1);
    chk("after_reset_value", value, 13);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
